// File: rtl/mem_arbiter.sv
// Multi-channel arbiter sharing a single memory port: one access in flight at a time,
// round-robin or fixed-priority grant, fixed read latency, per-channel done pulses.
module mem_arbiter #(
  parameter int NCH = 3,
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int LAT = 1,
  parameter int RR  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wdata,
  output logic [NCH-1:0]    stall,
  output logic [NCH-1:0]    done,
  output logic [DW-1:0]     rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNTW = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q;
  logic [CW-1:0]   win_q;
  logic [CW-1:0]   last_q;
  logic            lat_we_q;
  logic [DW-1:0]   rdata_q;
  logic [CW-1:0]   pick;
  logic [CW-1:0]   cand;
  logic            found;

  logic [AW-1:0] addr_ch  [NCH];
  logic [DW-1:0] wdata_ch [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign addr_ch[g]  = addr[g*AW +: AW];
    assign wdata_ch[g] = wdata[g*DW +: DW];
  end

  // Round-robin searches from the channel after the last winner; fixed priority from 0.
  // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int j = 0; j < NCH; j++) begin
      cand = (RR != 0) ? CW'((int'(last_q) + 1 + j) % NCH) : CW'(j);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = ISSUE;
      ISSUE:   state_d = (LAT == 1) ? DONE : WAIT;
      WAIT:    if (cnt_q == CNTW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      win_q     <= '0;
      last_q    <= CW'(NCH - 1);
      lat_we_q  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (|req) begin
          win_q     <= pick;
          lat_we_q  <= we[pick];
          mem_addr  <= addr_ch[pick];
          mem_wdata <= wdata_ch[pick];
        end
        ISSUE: begin
          last_q <= win_q;
          cnt_q  <= CNTW'(LAT - 1);
        end
        WAIT:    cnt_q <= cnt_q - CNTW'(1);
        DONE:    if (!lat_we_q) rdata_q <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Read data passes straight through during DONE and is then held for later cycles.
  always_comb begin
    mem_en = (state_q == ISSUE);
    mem_we = (state_q == ISSUE) && lat_we_q;
    done   = '0;
    if (state_q == DONE) done[win_q] = 1'b1;
    rdata  = (state_q == DONE && !lat_we_q) ? mem_rdata : rdata_q;
    stall  = req & ~done;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four configurations share one stimulus stream and are compared
// every cycle against a transaction-level model, plus directed scenario checks.
module tb_mem_arbiter;

  localparam int NCH = 3;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int NI  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    we;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] wdata;
  logic [DW-1:0]     mem_rdata;

  logic [NCH-1:0] stall_o     [NI];
  logic [NCH-1:0] done_o      [NI];
  logic [DW-1:0]  rdata_o     [NI];
  logic           mem_en_o    [NI];
  logic           mem_we_o    [NI];
  logic [AW-1:0]  mem_addr_o  [NI];
  logic [DW-1:0]  mem_wdata_o [NI];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Instance k: 0 = LAT1/RR, 1 = LAT3/RR, 2 = LAT4/fixed, 3 = LAT2/fixed
  function automatic int lat_of(int k);
    case (k)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int rr_of(int k);
    return (k < 2) ? 1 : 0;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_arbiter #(.NCH(NCH), .DW(DW), .AW(AW), .LAT(lat_of(g)), .RR(rr_of(g))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .stall     (stall_o[g]),
      .done      (done_o[g]),
      .rdata     (rdata_o[g]),
      .mem_en    (mem_en_o[g]),
      .mem_we    (mem_we_o[g]),
      .mem_addr  (mem_addr_o[g]),
      .mem_wdata (mem_wdata_o[g]),
      .mem_rdata (mem_rdata)
    );
  end

  // Model: age counts cycles since grant (1 = issue cycle, LAT+1 = done cycle, 0 = free).
  int          age     [NI];
  int          owner   [NI];
  int          last_w  [NI];
  bit          t_we    [NI];
  logic [31:0] t_addr  [NI];
  logic [31:0] t_wdata [NI];
  logic [31:0] last_rd [NI];

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      age[k]     = 0;
      owner[k]   = 0;
      last_w[k]  = NCH - 1;
      t_we[k]    = 1'b0;
      t_addr[k]  = '0;
      t_wdata[k] = '0;
      last_rd[k] = '0;
    end
  endtask

  function automatic int pick_winner(int k, logic [NCH-1:0] r);
    if (rr_of(k) != 0) begin
      for (int j = 1; j <= NCH; j++) begin
        int c;
        c = (last_w[k] + j) % NCH;
        if (r[c]) return c;
      end
    end else begin
      for (int i = 0; i < NCH; i++) if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < NI; k++) begin
      if (age[k] == 0) begin
        if (req != '0) begin
          int w;
          w          = pick_winner(k, req);
          owner[k]   = w;
          last_w[k]  = w;
          t_we[k]    = we[w];
          t_addr[k]  = addr[w*AW +: AW];
          t_wdata[k] = wdata[w*DW +: DW];
          age[k]     = 1;
        end
      end else if (age[k] == lat_of(k) + 1) begin
        if (!t_we[k]) last_rd[k] = mem_rdata;
        age[k] = 0;
      end else begin
        age[k] = age[k] + 1;
      end
    end
  endtask

  task automatic compare_outputs();
    for (int k = 0; k < NI; k++) begin
      logic [NCH-1:0] e_done;
      logic [NCH-1:0] e_stall;
      logic           e_en;
      logic           e_we;
      logic [DW-1:0]  e_rd;
      bit             fin;
      fin     = (age[k] == lat_of(k) + 1);
      e_done  = fin ? NCH'(1 << owner[k]) : '0;
      e_stall = req & ~e_done;
      e_en    = (age[k] == 1);
      e_we    = (age[k] == 1) && t_we[k];
      e_rd    = (fin && !t_we[k]) ? mem_rdata : last_rd[k];
      vectors += 7;
      if (done_o[k] !== e_done) begin
        miscompares++;
        $display("FAIL done inst%0d t=%0t: got %b expected %b", k, $time, done_o[k], e_done);
      end
      if (stall_o[k] !== e_stall) begin
        miscompares++;
        $display("FAIL stall inst%0d t=%0t: got %b expected %b", k, $time, stall_o[k], e_stall);
      end
      if (mem_en_o[k] !== e_en) begin
        miscompares++;
        $display("FAIL mem_en inst%0d t=%0t: got %b expected %b", k, $time, mem_en_o[k], e_en);
      end
      if (mem_we_o[k] !== e_we) begin
        miscompares++;
        $display("FAIL mem_we inst%0d t=%0t: got %b expected %b", k, $time, mem_we_o[k], e_we);
      end
      if (mem_addr_o[k] !== t_addr[k]) begin
        miscompares++;
        $display("FAIL mem_addr inst%0d t=%0t: got %h expected %h", k, $time, mem_addr_o[k], t_addr[k]);
      end
      if (mem_wdata_o[k] !== t_wdata[k]) begin
        miscompares++;
        $display("FAIL mem_wdata inst%0d t=%0t: got %h expected %h", k, $time, mem_wdata_o[k], t_wdata[k]);
      end
      if (rdata_o[k] !== e_rd) begin
        miscompares++;
        $display("FAIL rdata inst%0d t=%0t: got %h expected %h", k, $time, rdata_o[k], e_rd);
      end
    end
  endtask

  task automatic cycle_check();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic cycle_end();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic tick();
    cycle_check();
    cycle_end();
  endtask

  task automatic set_rst(bit v);
    rst_n = v;
    if (!v) model_reset();
  endtask

  task automatic apply_reset();
    req = '0;
    we  = '0;
    set_rst(1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  function automatic int ch_of(logic [NCH-1:0] d);
    for (int i = 0; i < NCH; i++) if (d[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    req = '0; we = '0; addr = '0; wdata = '0; mem_rdata = '0;
    rst_n = 1'b1;
    #1;
    set_rst(1'b0);
    #1;
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if ({done_o[k], stall_o[k], mem_en_o[k], mem_we_o[k]} !== '0 ||
          mem_addr_o[k] !== '0 || mem_wdata_o[k] !== '0 || rdata_o[k] !== '0) begin
        miscompares++;
        $display("FAIL reset_state inst%0d: got done=%b en=%b we=%b addr=%h wdata=%h rdata=%h expected all zero",
                 k, done_o[k], mem_en_o[k], mem_we_o[k], mem_addr_o[k], mem_wdata_o[k], rdata_o[k]);
      end
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single_read();
    apply_reset();
    req = 3'b001; we = 3'b000; addr = '0;
    addr[0 +: AW] = 32'h10;
    mem_rdata = 32'hDEADBEEF;
    for (int c = 1; c <= 3; c++) begin
      cycle_check();
      vectors++;
      case (c)
        1: if (stall_o[0] !== 3'b001 || mem_en_o[0] !== 1'b0) begin
             miscompares++;
             $display("FAIL rd_cycle1: got stall=%b en=%b expected stall=001 en=0", stall_o[0], mem_en_o[0]);
           end
        2: if (mem_en_o[0] !== 1'b1 || mem_we_o[0] !== 1'b0 || mem_addr_o[0] !== 32'h10 || stall_o[0] !== 3'b001) begin
             miscompares++;
             $display("FAIL rd_cycle2: got en=%b we=%b addr=%h stall=%b expected en=1 we=0 addr=10 stall=001",
                      mem_en_o[0], mem_we_o[0], mem_addr_o[0], stall_o[0]);
           end
        default: if (done_o[0] !== 3'b001 || rdata_o[0] !== 32'hDEADBEEF || stall_o[0] !== 3'b000) begin
             miscompares++;
             $display("FAIL rd_cycle3: got done=%b rdata=%h stall=%b expected done=001 rdata=deadbeef stall=000",
                      done_o[0], rdata_o[0], stall_o[0]);
           end
      endcase
      cycle_end();
    end
    req = '0;
    repeat (8) tick();
  endtask

  // LAT=3: issue in cycle 2, done in cycle 5 (fourth cycle counting the issue cycle).
  task automatic test_single_write();
    req = 3'b010; we = 3'b010;
    addr[AW +: AW]  = 32'h20;
    wdata[DW +: DW] = 32'h55;
    mem_rdata = 32'h12345678;
    for (int c = 1; c <= 5; c++) begin
      cycle_check();
      vectors++;
      if (c == 2) begin
        if (mem_en_o[1] !== 1'b1 || mem_we_o[1] !== 1'b1 || mem_addr_o[1] !== 32'h20 || mem_wdata_o[1] !== 32'h55) begin
          miscompares++;
          $display("FAIL wr_issue: got en=%b we=%b addr=%h wdata=%h expected en=1 we=1 addr=20 wdata=55",
                   mem_en_o[1], mem_we_o[1], mem_addr_o[1], mem_wdata_o[1]);
        end
      end else if (c == 5) begin
        if (done_o[1] !== 3'b010 || rdata_o[1] !== 32'hDEADBEEF) begin
          miscompares++;
          $display("FAIL wr_done: got done=%b rdata=%h expected done=010 rdata=deadbeef", done_o[1], rdata_o[1]);
        end
      end else begin
        if (mem_en_o[1] !== 1'b0 || done_o[1] !== 3'b000) begin
          miscompares++;
          $display("FAIL wr_quiet c%0d: got en=%b done=%b expected en=0 done=000", c, mem_en_o[1], done_o[1]);
        end
      end
      cycle_end();
    end
    req = '0; we = '0;
    repeat (8) tick();
  endtask

  task automatic test_round_robin();
    int order0[$];
    int order1[$];
    int cnt[NCH];
    apply_reset();
    req = 3'b111;
    for (int c = 0; c < 40; c++) begin
      cycle_check();
      if (done_o[0] != '0) order0.push_back(ch_of(done_o[0]));
      if (done_o[1] != '0) order1.push_back(ch_of(done_o[1]));
      cycle_end();
    end
    req = '0;
    vectors++;
    if (order0.size() < 12 || order1.size() < 3) begin
      miscompares++;
      $display("FAIL rr_count: got %0d/%0d completions expected at least 12/3", order0.size(), order1.size());
    end else begin
      for (int i = 0; i < NCH; i++) cnt[i] = 0;
      for (int i = 0; i < 12; i++) begin
        cnt[order0[i]]++;
        vectors++;
        if (order0[i] != i % NCH) begin
          miscompares++;
          $display("FAIL rr_order0[%0d]: got ch%0d expected ch%0d", i, order0[i], i % NCH);
        end
      end
      for (int i = 0; i < NCH; i++) begin
        vectors += 2;
        if (cnt[i] != 4) begin
          miscompares++;
          $display("FAIL rr_share ch%0d: got %0d expected 4", i, cnt[i]);
        end
        if (order1[i] != i) begin
          miscompares++;
          $display("FAIL rr_order1[%0d]: got ch%0d expected ch%0d", i, order1[i], i);
        end
      end
    end
    repeat (8) tick();
  endtask

  task automatic test_fixed_priority();
    int  n0;
    int  n_other;
    bit  seen;
    apply_reset();
    req = 3'b111;
    n0 = 0; n_other = 0;
    for (int c = 0; c < 30; c++) begin
      cycle_check();
      if (done_o[2][0] || done_o[3][0]) n0++;
      if (done_o[2][2:1] != '0 || done_o[3][2:1] != '0) n_other++;
      cycle_end();
    end
    vectors++;
    if (n_other != 0 || n0 < 8) begin
      miscompares++;
      $display("FAIL fp_hold: got ch0=%0d others=%0d expected ch0>=8 others=0", n0, n_other);
    end
    req = 3'b110;
    seen = 1'b0;
    n_other = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cycle_check();
      if (done_o[2][1]) seen = 1'b1;
      if (done_o[2][2]) n_other++;
      cycle_end();
    end
    vectors++;
    if (!seen || n_other != 0) begin
      miscompares++;
      $display("FAIL fp_handover: got ch1_seen=%0d ch2_dones=%0d expected 1 and 0", seen, n_other);
    end
    req = '0;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid();
    int bad;
    apply_reset();
    req = 3'b001; we = '0;
    addr[0 +: AW] = 32'h44;
    repeat (2) tick();
    req = '0;
    set_rst(1'b0);
    #1;
    vectors++;
    if ({done_o[2], stall_o[2], mem_en_o[2], mem_we_o[2]} !== '0 ||
        mem_addr_o[2] !== '0 || mem_wdata_o[2] !== '0 || rdata_o[2] !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got done=%b en=%b addr=%h rdata=%h expected all zero",
               done_o[2], mem_en_o[2], mem_addr_o[2], rdata_o[2]);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      cycle_check();
      if (done_o[2] != '0 || mem_en_o[2]) bad++;
      cycle_end();
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL reset_release: got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_req_drop();
    int n_en;
    int n_done;
    apply_reset();
    req = 3'b001; we = '0;
    tick();
    req = '0;
    n_en = 0; n_done = 0;
    for (int c = 0; c < 10; c++) begin
      cycle_check();
      if (mem_en_o[3]) n_en++;
      if (done_o[3] == 3'b001) n_done++;
      cycle_end();
    end
    vectors++;
    if (n_en != 1 || n_done != 1) begin
      miscompares++;
      $display("FAIL req_drop: got issues=%0d dones=%0d expected 1 and 1", n_en, n_done);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      req       = NCH'($urandom);
      we        = NCH'($urandom);
      addr      = {$urandom(), $urandom(), $urandom()};
      wdata     = {$urandom(), $urandom(), $urandom()};
      mem_rdata = $urandom();
      if ($urandom_range(0, 149) == 0) set_rst(1'b0);
      else rst_n = 1'b1;
      tick();
    end
    rst_n = 1'b1;
    req = '0;
    repeat (8) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    model_reset();
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_fixed_priority();
    test_reset_mid();
    test_req_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
